// File: rtl/accel_sha_pkg.sv
// Shared SHA-256 word types, scheduler state encoding and the bit-mixing
// functions used by both the message scheduler and the compressor.
package accel_sha_pkg;

   localparam int WORD_W        = 32;
   localparam int ROUNDS_SHA256 = 64;
   localparam int WIN_WORDS     = 16;
   localparam int IDX_W         = 7;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [IDX_W-1:0]  round_idx_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sched_state_t;

   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   // Message-schedule (small) sigmas.
   function automatic word_t sha_sigma0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t sha_sigma1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Compression-round functions.
   function automatic word_t sha_big_sigma0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t sha_big_sigma1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t sha_ch(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic word_t sha_maj(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/accel_sched_next_word.sv
// Combinational schedule expansion: nxt = sigma1(w14) + w9 + sigma0(w1) + w0 (mod 2^32).
// Kept in its own module so the adder tree can be pipelined or retimed in isolation.
module accel_sched_next_word
   import accel_sha_pkg::*;
(
   input  logic [WORD_W-1:0] w0,
   input  logic [WORD_W-1:0] w1,
   input  logic [WORD_W-1:0] w9,
   input  logic [WORD_W-1:0] w14,
   output logic [WORD_W-1:0] nxt
);

   logic [WORD_W-1:0] s0;
   logic [WORD_W-1:0] s1;

   assign s0  = sha_sigma0(w1);
   assign s1  = sha_sigma1(w14);
   assign nxt = (s1 + w9) + (s0 + w0);

endmodule

// File: rtl/accel_msg_scheduler.sv
// SHA-256 message scheduler: loads a 512-bit block, emits W[0..ROUNDS-1] one per advance.
// First word valid one cycle after load; advance low stalls w/i indefinitely; done pulses once.
module accel_msg_scheduler #(
   parameter int ROUNDS = accel_sha_pkg::ROUNDS_SHA256,
   parameter int WORD_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [16*WORD_W-1:0] blk_in,
   input  logic                 blk_valid,
   output logic                 blk_ready,
   input  logic                 advance,
   input  logic                 abort,
   output logic [WORD_W-1:0]    w,
   output logic [6:0]           i,
   output logic                 w_valid,
   output logic                 done
);

   import accel_sha_pkg::*;

   if (ROUNDS < 17 || ROUNDS > 127) begin : g_bad_rounds
      $error("accel_msg_scheduler: ROUNDS must be within 17..127");
   end
   if (WORD_W != 32) begin : g_bad_word
      $error("accel_msg_scheduler: WORD_W must be 32");
   end

   localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

   sched_state_t      state;
   logic [WORD_W-1:0] win [WIN_WORDS];
   logic [WORD_W-1:0] nxt;
   logic              load_fire;
   logic              adv_fire;
   logic              last_adv;

   assign blk_ready = (state == IDLE);
   assign load_fire = blk_valid && blk_ready;
   assign adv_fire  = advance && (state == RUN);
   assign last_adv  = adv_fire && (i == LAST_IDX);

   // The head of the window is the emitted word; it is a flop, so w stays registered.
   assign w = win[0];

   accel_sched_next_word u_next_word (
      .w0  (win[0]),
      .w1  (win[1]),
      .w9  (win[9]),
      .w14 (win[14]),
      .nxt (nxt)
   );

   // Abort leaves the window untouched; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < WIN_WORDS; k++) begin
            win[k] <= '0;
         end
      end else if (!abort) begin
         if (load_fire) begin
            for (int k = 0; k < WIN_WORDS; k++) begin
               win[k] <= blk_in[16*WORD_W-1 - WORD_W*k -: WORD_W];
            end
         end else if (adv_fire && !last_adv) begin
            for (int k = 0; k < WIN_WORDS-1; k++) begin
               win[k] <= win[k+1];
            end
            win[WIN_WORDS-1] <= nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || abort) begin
         state   <= IDLE;
         i       <= '0;
         w_valid <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (blk_valid) begin
                  state   <= RUN;
                  i       <= '0;
                  w_valid <= 1'b1;
               end
            end
            RUN: begin
               if (advance) begin
                  if (i == LAST_IDX) begin
                     state   <= DONE;
                     w_valid <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     i <= i + 7'd1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               w_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accel_msg_scheduler.sv
// Bench for accel_msg_scheduler: known-answer table, random blocks/stalls against a
// textbook schedule model, plus back-to-back, abort and synchronous-reset sequences.
module tb_accel_msg_scheduler;

   localparam int ROUNDS = 64;

   typedef struct {
      string        name;
      logic [511:0] blk;
      int           idx;
      logic [31:0]  expw;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [511:0] blk_in = '0;
   logic         blk_valid = 1'b0;
   logic         blk_ready;
   logic         advance = 1'b0;
   logic         abort = 1'b0;
   logic [31:0]  w;
   logic [6:0]   i;
   logic         w_valid;
   logic         done;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] exp_w [ROUNDS];
   logic [31:0] got_w [ROUNDS];
   vec_t        tbl [9];

   accel_msg_scheduler #(.ROUNDS(ROUNDS), .WORD_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .blk_in    (blk_in),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .advance   (advance),
      .abort     (abort),
      .w         (w),
      .i         (i),
      .w_valid   (w_valid),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, expv);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   // Textbook FIPS 180-4 expansion over the full W[] array.
   task automatic model_fill(input logic [511:0] blk);
      logic [31:0] s0;
      logic [31:0] s1;
      for (int t = 0; t < 16; t++) exp_w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < ROUNDS; t++) begin
         s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
         s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
         exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
      end
   endtask

   function automatic logic [511:0] rand_blk();
      logic [511:0] b;
      for (int k = 0; k < 16; k++) b[511 - 32*k -: 32] = $urandom;
      return b;
   endfunction

   task automatic load_block(input logic [511:0] blk);
      blk_in    = blk;
      blk_valid = 1'b1;
      step();
      blk_valid = 1'b0;
      chk("load_w_valid", 32'(w_valid), 1);
      chk("load_i", 32'(i), 0);
   endtask

   // Entered just after the load edge; leaves in the DONE cycle.
   task automatic run_words(input int gap_at, input int gap_len, input bit rnd);
      int k = 0;
      int edges = 0;
      int stalls = 0;
      int gap_done = 0;
      bit adv;
      while (k < ROUNDS) begin
         chk("run_w_valid", 32'(w_valid), 1);
         chk("run_i", 32'(i), 32'(k));
         chk("run_w", w, exp_w[k]);
         chk("run_no_done", 32'(done), 0);
         chk("run_ready_low", 32'(blk_ready), 0);
         adv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (k == gap_at && gap_done < gap_len) begin
            adv = 1'b0;
            gap_done++;
         end
         if (adv) got_w[k] = w;
         else stalls++;
         advance = adv;
         step();
         edges++;
         if (adv) k++;
      end
      advance = 1'b0;
      chk("done_pulse", 32'(done), 1);
      chk("done_w_valid", 32'(w_valid), 0);
      chk("done_ready_low", 32'(blk_ready), 0);
      // First w_valid cycle counts as cycle 1, so done lands in cycle ROUNDS+1 (+stalls).
      chk("done_cycle", 32'(edges + 1), 32'(ROUNDS + 1 + stalls));
   endtask

   // Advance held high through DONE must not disturb the return to IDLE.
   task automatic finish_idle();
      advance = 1'b1;
      step();
      advance = 1'b0;
      chk("post_done_low", 32'(done), 0);
      chk("post_ready", 32'(blk_ready), 1);
      chk("post_w_valid", 32'(w_valid), 0);
   endtask

   initial begin
      logic [511:0] abc_blk;
      logic [511:0] ones_blk;
      logic [511:0] msb_blk;
      logic [511:0] zero_blk;
      logic [511:0] blk_a;
      logic [511:0] blk_b;

      abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
      ones_blk = {512{1'b1}};
      msb_blk  = {16{32'h80000000}};
      zero_blk = '0;

      tbl[0] = '{"abc_w0",  abc_blk,  0,  32'h61626380};
      tbl[1] = '{"abc_w1",  abc_blk,  1,  32'h00000000};
      tbl[2] = '{"abc_w15", abc_blk,  15, 32'h00000018};
      tbl[3] = '{"abc_w16", abc_blk,  16, 32'h61626380};
      tbl[4] = '{"abc_w17", abc_blk,  17, 32'h000F0000};
      tbl[5] = '{"ones_w0", ones_blk, 0,  32'hFFFFFFFF};
      tbl[6] = '{"msb_w16", msb_blk,  16, 32'h11207000};
      tbl[7] = '{"msb_w17", msb_blk,  17, 32'h11207000};
      tbl[8] = '{"zero_w63", zero_blk, 63, 32'h00000000};

      // Reset state
      step();
      step();
      rst_n = 1'b1;
      chk("rst_w", w, 0);
      chk("rst_i", 32'(i), 0);
      chk("rst_w_valid", 32'(w_valid), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ready", 32'(blk_ready), 1);

      // Advance while IDLE does nothing
      advance = 1'b1;
      repeat (3) step();
      advance = 1'b0;
      chk("idle_adv_w_valid", 32'(w_valid), 0);
      chk("idle_adv_i", 32'(i), 0);
      chk("idle_adv_done", 32'(done), 0);
      chk("idle_adv_ready", 32'(blk_ready), 1);

      // Known-answer table
      for (int n = 0; n < 9; n++) begin
         model_fill(tbl[n].blk);
         load_block(tbl[n].blk);
         run_words(-1, 0, 1'b0);
         finish_idle();
         chk(tbl[n].name, got_w[tbl[n].idx], tbl[n].expw);
      end

      // abc with a 5-cycle gap at i=20
      model_fill(abc_blk);
      load_block(abc_blk);
      run_words(20, 5, 1'b0);
      finish_idle();
      chk("abc_gap_w17", got_w[17], 32'h000F0000);

      // Random blocks, random stalls
      for (int r = 0; r < 4; r++) begin
         blk_a = rand_blk();
         model_fill(blk_a);
         load_block(blk_a);
         run_words($urandom_range(0, ROUNDS-1), $urandom_range(1, 6), 1'b1);
         finish_idle();
      end

      // Back-to-back with blk_valid held high
      blk_a = rand_blk();
      blk_b = rand_blk();
      model_fill(blk_a);
      blk_in    = blk_a;
      blk_valid = 1'b1;
      step();
      chk("b2b_a_valid", 32'(w_valid), 1);
      run_words(-1, 0, 1'b0);
      blk_in = blk_b;
      step();
      chk("b2b_idle_ready", 32'(blk_ready), 1);
      chk("b2b_idle_w_valid", 32'(w_valid), 0);
      chk("b2b_idle_done", 32'(done), 0);
      step();
      blk_valid = 1'b0;
      model_fill(blk_b);
      chk("b2b_b_valid", 32'(w_valid), 1);
      chk("b2b_b_w0", w, exp_w[0]);
      run_words(-1, 0, 1'b0);
      finish_idle();

      // Abort at i=30 together with advance
      blk_a = rand_blk();
      model_fill(blk_a);
      load_block(blk_a);
      advance = 1'b1;
      repeat (30) step();
      advance = 1'b0;
      chk("abort_pre_i", 32'(i), 30);
      chk("abort_pre_w", w, exp_w[30]);
      abort   = 1'b1;
      advance = 1'b1;
      step();
      abort   = 1'b0;
      advance = 1'b0;
      chk("abort_w_valid", 32'(w_valid), 0);
      chk("abort_i", 32'(i), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_ready", 32'(blk_ready), 1);
      repeat (3) begin
         step();
         chk("abort_no_done", 32'(done), 0);
      end
      model_fill(ones_blk);
      load_block(ones_blk);
      chk("abort_ones_w0", w, 32'hFFFFFFFF);
      run_words(-1, 0, 1'b0);
      finish_idle();

      // Abort beats blk_valid in IDLE
      blk_in    = ones_blk;
      blk_valid = 1'b1;
      abort     = 1'b1;
      step();
      abort     = 1'b0;
      blk_valid = 1'b0;
      chk("abort_idle_w_valid", 32'(w_valid), 0);
      chk("abort_idle_ready", 32'(blk_ready), 1);
      step();
      chk("abort_idle_still", 32'(w_valid), 0);

      // Synchronous reset at i=40
      blk_a = rand_blk();
      model_fill(blk_a);
      load_block(blk_a);
      advance = 1'b1;
      repeat (40) step();
      advance = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("rst_noedge_i", 32'(i), 40);
      chk("rst_noedge_w", w, exp_w[40]);
      chk("rst_noedge_w_valid", 32'(w_valid), 1);
      step();
      rst_n = 1'b1;
      chk("rst_mid_w", w, 0);
      chk("rst_mid_i", 32'(i), 0);
      chk("rst_mid_w_valid", 32'(w_valid), 0);
      chk("rst_mid_ready", 32'(blk_ready), 1);
      step();
      chk("rst_rel_w", w, 0);
      chk("rst_rel_i", 32'(i), 0);
      chk("rst_rel_w_valid", 32'(w_valid), 0);
      chk("rst_rel_done", 32'(done), 0);
      chk("rst_rel_ready", 32'(blk_ready), 1);

      // Scheduler still healthy after reset
      model_fill(msb_blk);
      load_block(msb_blk);
      run_words(-1, 0, 1'b1);
      finish_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
